// File: rtl/formula_sweep_checker_if.sv
// Sweep control/result bundle between a sweep master and the formula sweep checker.
interface formula_sweep_checker_if #(
  parameter int N_IN  = 31,
  parameter int CNT_W = 32
);
  logic             start;
  logic             abort;
  logic             mode;
  logic             stop_on_fail;
  logic [N_IN-1:0]  base;
  logic [CNT_W-1:0] count;
  logic [N_IN-1:0]  vec_out;
  logic             vec_valid;
  logic             f_in;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [N_IN-1:0]  first_fail_vec;
  logic             first_fail_vld;

  modport master (
    output start, abort, mode, stop_on_fail, base, count, f_in,
    input  vec_out, vec_valid, busy, done, aborted,
           pass_cnt, fail_cnt, first_fail_vec, first_fail_vld
  );

  modport slave (
    input  start, abort, mode, stop_on_fail, base, count, f_in,
    output vec_out, vec_valid, busy, done, aborted,
           pass_cnt, fail_cnt, first_fail_vec, first_fail_vld
  );
endinterface

// File: rtl/formula_sweep_checker.sv
// Drives a sweep of assignments onto a combinational formula, samples its
// output once per assignment, counts pass/fail and captures the first failure.
module formula_sweep_checker #(
  parameter int N_IN  = 31,
  parameter int CNT_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  formula_sweep_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             sof_q, sof_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic             ffvld_q, ffvld_d;
  logic             aborted_q, aborted_d;

  logic [N_IN-1:0]  vec_next;

  // Next assignment: binary increment, or x^31+x^28+1 Fibonacci LFSR step.
  always_comb begin
    if (mode_q) vec_next = {vec_q[N_IN-2:0], vec_q[N_IN-1] ^ vec_q[N_IN-4]};
    else        vec_next = vec_q + N_IN'(1);
  end

  // Sweep FSM next-state and result update; f_in is judged against the
  // vector currently on vec_out, so sampling adds no latency.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    sof_d     = sof_q;
    vec_d     = vec_q;
    rem_d     = rem_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    ffv_d     = ffv_q;
    ffvld_d   = ffvld_q;
    aborted_d = aborted_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d    = bus.mode;
          sof_d     = bus.stop_on_fail;
          rem_d     = bus.count;
          pass_d    = '0;
          fail_d    = '0;
          ffv_d     = '0;
          ffvld_d   = 1'b0;
          aborted_d = 1'b0;
          if (bus.count != '0) begin
            // The all-zero state is the LFSR lock-up state, so seed with 1.
            vec_d   = (bus.mode && bus.base == '0) ? N_IN'(1) : bus.base;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          // Abort wins over a sample, including the final one.
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          if (bus.f_in) begin
            if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
          end else begin
            if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
            if (!ffvld_q) begin
              ffv_d   = vec_q;
              ffvld_d = 1'b1;
            end
          end
          rem_d = rem_q - CNT_W'(1);
          vec_d = vec_next;
          if (rem_q == CNT_W'(1) || (!bus.f_in && sof_q)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset clears everything including results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      sof_q     <= 1'b0;
      vec_q     <= '0;
      rem_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      ffv_q     <= '0;
      ffvld_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      sof_q     <= sof_d;
      vec_q     <= vec_d;
      rem_q     <= rem_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      ffv_q     <= ffv_d;
      ffvld_q   <= ffvld_d;
      aborted_q <= aborted_d;
    end
  end

  // Outputs are straight decodes of registered state.
  always_comb begin
    bus.vec_out        = vec_q;
    bus.vec_valid      = (state_q == S_RUN);
    bus.busy           = (state_q == S_RUN);
    bus.done           = (state_q == S_DONE);
    bus.aborted        = aborted_q;
    bus.pass_cnt       = pass_q;
    bus.fail_cnt       = fail_q;
    bus.first_fail_vec = ffv_q;
    bus.first_fail_vld = ffvld_q;
  end

endmodule

// File: tb/tb_formula_sweep_checker.sv
// Bench for formula_sweep_checker: directed table plus randomized sweeps
// scored against a sequence-level reference model.
module tb_formula_sweep_checker;
  localparam int N_IN  = 31;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   fsel;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  formula_sweep_checker_if #(.N_IN(N_IN), .CNT_W(CNT_W)) ifc ();

  formula_sweep_checker #(.N_IN(N_IN), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  typedef struct {
    logic [30:0] base;
    logic [31:0] count;
    logic        mode;
    logic        sof;
    int          fsel;
    int          abort_at;
    logic [31:0] e_pass;
    logic [31:0] e_fail;
    logic [30:0] e_ffv;
    logic        e_ffvld;
    logic        e_ab;
    int          e_lat;
    int          e_runs;
  } vec_t;

  logic [30:0] exp_q[$];

  // Stand-in formula netlist selected by fsel.
  function automatic bit formula(input logic [30:0] v, input int sel);
    case (sel)
      0: return ~v[0];
      1: return 1'b1;
      2: return (v != 31'd8);
      3: return 1'b0;
      default: return (~(v[3] & v[1])) ^ v[10];
    endcase
  endfunction

  assign ifc.f_in = formula(ifc.vec_out, fsel);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [30:0] base, input logic [31:0] cnt, input logic mode,
                              input logic sof, input int fs, input int ab, input logic [31:0] ep,
                              input logic [31:0] ef, input logic [30:0] effv, input logic effvld,
                              input logic eab, input int elat);
    vec_t t;
    t.base = base; t.count = cnt; t.mode = mode; t.sof = sof; t.fsel = fs; t.abort_at = ab;
    t.e_pass = ep; t.e_fail = ef; t.e_ffv = effv; t.e_ffvld = effvld; t.e_ab = eab;
    t.e_lat = elat; t.e_runs = 0;
    return t;
  endfunction

  // Reference: walk the assignment sequence arithmetically and tally results.
  task automatic model(input vec_t t, output vec_t r);
    logic [30:0] v;
    bit          stop;
    int          samples;
    r = t;
    exp_q.delete();
    r.e_pass = 0; r.e_fail = 0; r.e_ffv = 0; r.e_ffvld = 0; r.e_ab = 0;
    v = (t.mode && t.base == 0) ? 31'd1 : t.base;
    stop = 0;
    samples = 0;
    for (int i = 0; i < int'(t.count) && !stop; i++) begin
      if (i == t.abort_at) begin
        r.e_ab = 1; stop = 1;
      end else begin
        exp_q.push_back(v);
        samples++;
        if (formula(v, t.fsel)) r.e_pass++;
        else begin
          r.e_fail++;
          if (!r.e_ffvld) begin r.e_ffv = v; r.e_ffvld = 1; end
          if (t.sof) stop = 1;
        end
        if (t.mode) v = 31'((v << 1) | (((v >> 30) ^ (v >> 27)) & 31'd1));
        else        v = 31'(v + 31'd1);
      end
    end
    r.e_runs = samples + (r.e_ab ? 1 : 0);
    r.e_lat  = r.e_runs + 1;
  endtask

  // Apply one sweep; vector order comes from the model, results from t.
  task automatic run_sweep(input vec_t t, input string tag);
    vec_t m;
    int   cyc, k, budget;
    bit   got_done;
    model(t, m);
    budget = m.e_lat + 10;
    fsel = t.fsel;
    @(negedge clk);
    ifc.base = t.base; ifc.count = t.count; ifc.mode = t.mode;
    ifc.stop_on_fail = t.sof; ifc.start = 1'b1;
    @(negedge clk);
    cyc = 1; k = 0; got_done = 0;
    while (!got_done && cyc <= budget) begin
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      if (ifc.done) begin
        got_done = 1;
        chk({tag, " latency"}, 64'(cyc), 64'(t.e_lat));
        chk({tag, " run_cycles"}, 64'(k), 64'(m.e_runs));
        chk({tag, " pass_cnt"}, 64'(ifc.pass_cnt), 64'(t.e_pass));
        chk({tag, " fail_cnt"}, 64'(ifc.fail_cnt), 64'(t.e_fail));
        chk({tag, " ff_vld"}, 64'(ifc.first_fail_vld), 64'(t.e_ffvld));
        if (t.e_ffvld) chk({tag, " ff_vec"}, 64'(ifc.first_fail_vec), 64'(t.e_ffv));
        chk({tag, " aborted"}, 64'(ifc.aborted), 64'(t.e_ab));
        chk({tag, " busy_in_done"}, 64'(ifc.busy), 64'd0);
      end else begin
        if (ifc.busy) begin
          chk({tag, " vec_valid"}, 64'(ifc.vec_valid), 64'd1);
          if (k < exp_q.size()) chk({tag, " vec_out"}, 64'(ifc.vec_out), 64'(exp_q[k]));
          if (k == t.abort_at) ifc.abort = 1'b1;
          if (k == 1) ifc.start = 1'b1;
          k++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) chk({tag, " done_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, 64'({ifc.done, ifc.busy, ifc.vec_valid}), 64'd0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t r;
    rst = 1'b1; fsel = 1;
    ifc.start = 0; ifc.abort = 0; ifc.mode = 0; ifc.stop_on_fail = 0;
    ifc.base = '0; ifc.count = '0;

    // Directed table: base, count, mode, sof, formula, abort_at | pass, fail, ffv, ffvld, aborted, latency
    tbl.push_back(mk(31'd0,          32'd4,   0, 0, 0, -1, 2, 2, 31'd1,          1, 0, 5));
    tbl.push_back(mk(31'h7FFF_FFFE,  32'd3,   0, 0, 1, -1, 3, 0, 31'd0,          0, 0, 4));
    tbl.push_back(mk(31'd0,          32'd3,   1, 0, 1, -1, 3, 0, 31'd0,          0, 0, 4));
    tbl.push_back(mk(31'd5,          32'd100, 0, 1, 2, -1, 3, 1, 31'd8,          1, 0, 5));
    tbl.push_back(mk(31'd0,          32'd10,  0, 0, 1,  2, 2, 0, 31'd0,          0, 1, 4));
    tbl.push_back(mk(31'd9,          32'd0,   0, 0, 3, -1, 0, 0, 31'd0,          0, 0, 1));
    tbl.push_back(mk(31'h4000_0000,  32'd3,   1, 0, 3, -1, 0, 3, 31'h4000_0000,  1, 0, 4));
    tbl.push_back(mk(31'd0,          32'd3,   0, 0, 1,  2, 2, 0, 31'd0,          0, 1, 4));

    repeat (2) @(negedge clk);
    chk("reset busy", 64'(ifc.busy), 64'd0);
    chk("reset done", 64'(ifc.done), 64'd0);
    chk("reset vec", 64'({ifc.vec_out, ifc.vec_valid}), 64'd0);
    chk("reset cnts", {ifc.pass_cnt, ifc.fail_cnt}, 64'd0);
    chk("reset ff", 64'({ifc.first_fail_vec, ifc.first_fail_vld, ifc.aborted}), 64'd0);
    rst = 1'b0;

    foreach (tbl[i]) run_sweep(tbl[i], $sformatf("dir%0d", i));

    // Reset in the middle of a failing sweep: back to idle, results cleared, no done.
    fsel = 3;
    @(negedge clk);
    ifc.base = 31'd20; ifc.count = 32'd10; ifc.mode = 0; ifc.stop_on_fail = 0; ifc.start = 1'b1;
    @(negedge clk); ifc.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst pre busy", 64'(ifc.busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", 64'({ifc.busy, ifc.vec_valid, ifc.done}), 64'd0);
    chk("midrst cnts", {ifc.pass_cnt, ifc.fail_cnt}, 64'd0);
    chk("midrst ff", 64'({ifc.first_fail_vec, ifc.first_fail_vld, ifc.aborted}), 64'd0);
    chk("midrst vec", 64'(ifc.vec_out), 64'd0);
    begin
      bit seen = 0;
      repeat (6) begin @(negedge clk); if (ifc.done || ifc.busy) seen = 1; end
      chk("midrst no_done", 64'(seen), 64'd0);
    end

    // Abort while idle must not set aborted.
    ifc.abort = 1'b1;
    @(negedge clk);
    ifc.abort = 1'b0;
    chk("idle abort ignored", 64'(ifc.aborted), 64'd0);

    // Randomized sweeps scored against the model.
    for (int i = 0; i < 40; i++) begin
      vec_t t;
      t = mk(31'($urandom), 32'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), -1, 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 3) == 0) t.abort_at = int'($urandom_range(0, int'(t.count) + 2));
      model(t, r);
      run_sweep(r, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
